// File: rtl/dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_ctrl                                                     |
// | Purpose  : Data-side memory controller behind the ME stage. Turns one    |
// |            word-level load/store into a sequence of byte accesses on an  |
// |            external 8-bit bus, reports busy/done back to ME and returns  |
// |            the assembled 32-bit read word.                               |
// | Ports    :                                                               |
// |   clk           clock, all state on rising edge                          |
// |   rst           asynchronous active-low reset                            |
// |   ram_r_enable  load request from ME                                     |
// |   ram_w_enable  store request from ME (wins over a simultaneous load)    |
// |   ram_w_mask    byte-lane write enables, bit i = lane i                  |
// |   ram_w_data    store data, lane i = bits [8i+7:8i]                      |
// |   ram_addr      request address; low 2 bits ignored                      |
// |   ram_r_data    assembled read word, held until the next load completes  |
// |   ram_busy      transaction in progress                                  |
// |   ram_done      one-cycle completion pulse                               |
// |   mem_addr      external byte address                                    |
// |   mem_dout      external write byte                                      |
// |   mem_din       external read byte (1-cycle latency after mem_addr)      |
// |   mem_wr        external write strobe for the current byte               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_ctrl #(
  parameter int MEM_ADDR_W = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ram_r_enable,
  input  logic                  ram_w_enable,
  input  logic [3:0]            ram_w_mask,
  input  logic [31:0]           ram_w_data,
  input  logic [31:0]           ram_addr,
  output logic [31:0]           ram_r_data,
  output logic                  ram_busy,
  output logic                  ram_done,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic [7:0]            mem_dout,
  input  logic [7:0]            mem_din,
  output logic                  mem_wr
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A load needs one extra cycle to catch the last byte coming back.
  localparam logic [2:0] C_READ_LAST  = 3'd4;
  localparam logic [2:0] C_WRITE_LAST = 3'd3;

  state_t                r_state;
  logic [2:0]            r_cnt;
  logic [MEM_ADDR_W-1:0] r_base;
  logic [3:0]            r_mask;
  logic [31:0]           r_wdata;
  logic [23:0]           r_rbuf;

  logic [1:0]            w_next_lane;
  logic [MEM_ADDR_W-1:0] w_next_addr;
  logic [MEM_ADDR_W-1:0] w_req_base;
  logic                  w_unused_addr_bits;

  // Truncating before the add is equivalent to adding in 32 bits and
  // truncating afterwards: the result wraps modulo 2^MEM_ADDR_W either way.
  assign w_req_base  = {ram_addr[MEM_ADDR_W-1:2], 2'b00};
  assign w_next_lane = r_cnt[1:0] + 2'd1;
  assign w_next_addr = r_base + MEM_ADDR_W'(w_next_lane);

  // Address bits above the external bus width and the byte offset play no
  // part in addressing.
  assign w_unused_addr_bits = ^{ram_addr[31:MEM_ADDR_W], ram_addr[1:0]};

  // Every bus output is registered one cycle ahead: the edge that moves the
  // counter to k also loads the address/data/strobe for byte k.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 3'd0;
      r_base     <= '0;
      r_mask     <= 4'd0;
      r_wdata    <= 32'd0;
      r_rbuf     <= 24'd0;
      ram_r_data <= 32'd0;
      ram_busy   <= 1'b0;
      ram_done   <= 1'b0;
      mem_addr   <= '0;
      mem_dout   <= 8'd0;
      mem_wr     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          ram_done <= 1'b0;
          r_cnt    <= 3'd0;
          if (ram_w_enable) begin
            r_base   <= w_req_base;
            r_mask   <= ram_w_mask;
            r_wdata  <= ram_w_data;
            mem_addr <= w_req_base;
            mem_dout <= ram_w_data[7:0];
            mem_wr   <= ram_w_mask[0];
            ram_busy <= 1'b1;
            r_state  <= ST_WRITE;
          end else if (ram_r_enable) begin
            r_base   <= w_req_base;
            mem_addr <= w_req_base;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
            ram_busy <= 1'b1;
            r_state  <= ST_READ;
          end
        end

        ST_READ: begin
          // mem_din in the cycle with counter k belongs to byte k-1.
          case (r_cnt)
            3'd1:    r_rbuf[7:0]   <= mem_din;
            3'd2:    r_rbuf[15:8]  <= mem_din;
            3'd3:    r_rbuf[23:16] <= mem_din;
            default: r_rbuf        <= r_rbuf;
          endcase
          if (r_cnt == C_READ_LAST) begin
            ram_r_data <= {mem_din, r_rbuf};
            ram_busy   <= 1'b0;
            ram_done   <= 1'b1;
            mem_addr   <= '0;
            r_cnt      <= 3'd0;
            r_state    <= ST_DONE;
          end else begin
            // The final capture cycle issues no new address; base+3 holds.
            if (r_cnt < 3'd3) begin
              mem_addr <= w_next_addr;
            end
            r_cnt <= r_cnt + 3'd1;
          end
        end

        ST_WRITE: begin
          if (r_cnt == C_WRITE_LAST) begin
            ram_busy <= 1'b0;
            ram_done <= 1'b1;
            mem_addr <= '0;
            mem_dout <= 8'd0;
            mem_wr   <= 1'b0;
            r_cnt    <= 3'd0;
            r_state  <= ST_DONE;
          end else begin
            // Unmasked lanes still get their cycle, just without the strobe.
            mem_addr <= w_next_addr;
            mem_dout <= r_wdata[{w_next_lane, 3'b000} +: 8];
            mem_wr   <= r_mask[w_next_lane];
            r_cnt    <= r_cnt + 3'd1;
          end
        end

        ST_DONE: begin
          ram_done <= 1'b0;
          r_cnt    <= 3'd0;
          r_state  <= ST_IDLE;
        end

        default: begin
          ram_busy <= 1'b0;
          ram_done <= 1'b0;
          mem_wr   <= 1'b0;
          r_cnt    <= 3'd0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_ctrl                                                  |
// | Purpose  : Self-checking bench for dmem_ctrl with a byte-array external  |
// |            memory and a word-level reference model of memory contents.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_ctrl;

  localparam int AW       = 17;
  localparam int MEM_SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          ram_r_enable;
  logic          ram_w_enable;
  logic [3:0]    ram_w_mask;
  logic [31:0]   ram_w_data;
  logic [31:0]   ram_addr;
  logic [31:0]   ram_r_data;
  logic          ram_busy;
  logic          ram_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic          mem_wr;

  logic          pre_en;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;

  logic [7:0]    bus_mem [0:MEM_SIZE-1];
  logic [7:0]    ref_mem [0:MEM_SIZE-1];
  logic [31:0]   exp_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.MEM_ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .ram_r_enable (ram_r_enable),
    .ram_w_enable (ram_w_enable),
    .ram_w_mask   (ram_w_mask),
    .ram_w_data   (ram_w_data),
    .ram_addr     (ram_addr),
    .ram_r_data   (ram_r_data),
    .ram_busy     (ram_busy),
    .ram_done     (ram_done),
    .mem_addr     (mem_addr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din),
    .mem_wr       (mem_wr)
  );

  // External synchronous byte memory: read data one cycle after address.
  always @(posedge clk) begin
    if (pre_en) bus_mem[pre_addr] <= pre_data;
    else if (mem_wr) bus_mem[mem_addr] <= mem_dout;
    mem_din <= bus_mem[mem_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Byte i of the word containing addr, wrapped to the external bus width.
  function automatic logic [AW-1:0] byte_addr(input logic [31:0] addr, input int i);
    logic [31:0] s;
    s = (addr & 32'hFFFF_FFFC) + 32'(i);
    return s[AW-1:0];
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_en   = 1'b1;
    pre_addr = a;
    pre_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pre_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Issue one request (at least one enable set) from an IDLE cycle and check
  // the whole transaction. Returns in the first IDLE cycle after ram_done.
  task automatic run_txn(input logic we, input logic re, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data, input string tag);
    int n;
    int done_cyc;
    int lane;
    bit busy_ok;
    bit bus_ok;
    bit mem_ok;
    logic [AW-1:0] exp_a;
    n = we ? 4 : 5;
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) ref_mem[byte_addr(addr, i)] = data[8*i +: 8];
      end
    end else begin
      exp_rdata = {ref_mem[byte_addr(addr, 3)], ref_mem[byte_addr(addr, 2)],
                   ref_mem[byte_addr(addr, 1)], ref_mem[byte_addr(addr, 0)]};
    end
    ram_w_enable = we;
    ram_r_enable = re;
    ram_addr     = addr;
    ram_w_mask   = mask;
    ram_w_data   = data;
    done_cyc = 0;
    busy_ok  = 1'b1;
    bus_ok   = 1'b1;
    for (int k = 1; k <= 12 && done_cyc == 0; k++) begin
      @(posedge clk); #1;
      // Requests are garbage while busy/done; the DUT must ignore them.
      ram_w_enable = 1'($urandom);
      ram_r_enable = 1'($urandom);
      ram_w_mask   = 4'($urandom);
      ram_w_data   = $urandom;
      ram_addr     = $urandom;
      if (ram_done === 1'b1) begin
        done_cyc = k;
      end else begin
        if (ram_busy !== (k <= n)) busy_ok = 1'b0;
        if (k <= n) begin
          lane  = (k <= 4) ? k - 1 : 3;
          exp_a = byte_addr(addr, lane);
          if (mem_addr !== exp_a) bus_ok = 1'b0;
          if (we) begin
            if (mem_wr !== mask[lane] || mem_dout !== data[8*lane +: 8]) bus_ok = 1'b0;
          end else if (mem_wr !== 1'b0) begin
            bus_ok = 1'b0;
          end
        end
      end
    end
    checks++;
    if (done_cyc !== n + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d want %0d", tag, done_cyc, n + 1);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy_window: got wrong ram_busy pattern, want high cycles 1..%0d", tag, n);
    end
    checks++;
    if (!bus_ok) begin
      errors++;
      $display("FAIL %s bus_sequence: got wrong mem_addr/mem_wr/mem_dout sequence, want base 0x%05h", tag, byte_addr(addr, 0));
    end
    checks++;
    if (ram_r_data !== exp_rdata) begin
      errors++;
      $display("FAIL %s r_data: got 0x%08h want 0x%08h", tag, ram_r_data, exp_rdata);
    end
    checks++;
    if (ram_busy !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== '0 || mem_dout !== 8'd0) begin
      errors++;
      $display("FAIL %s done_bus_idle: got busy=%b wr=%b addr=0x%05h dout=0x%02h want all 0",
               tag, ram_busy, mem_wr, mem_addr, mem_dout);
    end
    @(posedge clk); #1;
    ram_w_enable = 1'b0;
    ram_r_enable = 1'b0;
    ram_w_mask   = 4'd0;
    ram_w_data   = 32'd0;
    ram_addr     = 32'd0;
    checks++;
    if (ram_done !== 1'b0 || ram_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b want 0 0", tag, ram_done, ram_busy);
    end
    if (we) begin
      mem_ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (bus_mem[byte_addr(addr, i)] !== ref_mem[byte_addr(addr, i)]) mem_ok = 1'b0;
      end
      checks++;
      if (!mem_ok) begin
        errors++;
        $display("FAIL %s mem_bytes: got %02h %02h %02h %02h want %02h %02h %02h %02h", tag,
                 bus_mem[byte_addr(addr, 0)], bus_mem[byte_addr(addr, 1)],
                 bus_mem[byte_addr(addr, 2)], bus_mem[byte_addr(addr, 3)],
                 ref_mem[byte_addr(addr, 0)], ref_mem[byte_addr(addr, 1)],
                 ref_mem[byte_addr(addr, 2)], ref_mem[byte_addr(addr, 3)]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    ram_r_enable = 1'b0;
    ram_w_enable = 1'b0;
    ram_w_mask   = 4'd0;
    ram_w_data   = 32'd0;
    ram_addr     = 32'd0;
    pre_en = 1'b0;
    pre_addr = '0;
    pre_data = 8'd0;
    exp_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    idle(3);
    checks++;
    if (ram_busy !== 1'b0 || ram_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_handshake: got busy=%b done=%b want 0 0", ram_busy, ram_done);
    end
    checks++;
    if (mem_wr !== 1'b0 || mem_addr !== '0 || mem_dout !== 8'd0) begin
      errors++;
      $display("FAIL reset_bus: got wr=%b addr=0x%05h dout=0x%02h want 0", mem_wr, mem_addr, mem_dout);
    end
    checks++;
    if (ram_r_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_r_data: got 0x%08h want 0x00000000", ram_r_data);
    end
  endtask

  task automatic test_load_basic();
    run_txn(1'b0, 1'b1, 32'h0000_0102, 4'd0, 32'd0, "load_0x102");
    idle(3);
    checks++;
    if (ram_r_data !== 32'h4433_2211) begin
      errors++;
      $display("FAIL load_hold: got 0x%08h want 0x44332211", ram_r_data);
    end
  endtask

  task automatic test_store_lane();
    run_txn(1'b1, 1'b0, 32'h0000_0201, 4'b0010, 32'hAAAA_AAAA, "store_0x201_lane1");
    idle(1);
  endtask

  task automatic test_both_enables();
    run_txn(1'b1, 1'b1, 32'h0000_0300, 4'b1111, 32'hDEAD_BEEF, "both_en_0x300");
    checks++;
    if (bus_mem[17'h300] !== 8'hEF || bus_mem[17'h301] !== 8'hBE ||
        bus_mem[17'h302] !== 8'hAD || bus_mem[17'h303] !== 8'hDE) begin
      errors++;
      $display("FAIL both_en_bytes: got %02h %02h %02h %02h want ef be ad de",
               bus_mem[17'h300], bus_mem[17'h301], bus_mem[17'h302], bus_mem[17'h303]);
    end
  endtask

  task automatic test_reset_mid_read();
    ram_r_enable = 1'b1;
    ram_addr     = 32'h0000_0100;
    @(posedge clk); #1;
    ram_r_enable = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    exp_rdata = 32'd0;
    checks++;
    if (ram_busy !== 1'b0 || ram_done !== 1'b0 || mem_wr !== 1'b0 ||
        mem_addr !== '0 || mem_dout !== 8'd0 || ram_r_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_read: got busy=%b done=%b wr=%b addr=0x%05h dout=0x%02h rdata=0x%08h want all 0",
               ram_busy, ram_done, mem_wr, mem_addr, mem_dout, ram_r_data);
    end
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    run_txn(1'b0, 1'b1, 32'h0000_0100, 4'd0, 32'd0, "load_after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    d = $urandom;
    run_txn(1'b1, 1'b0, 32'h0000_0302, 4'b1111, d, "b2b_store");
    run_txn(1'b0, 1'b1, 32'h0000_0301, 4'd0, 32'd0, "b2b_load");
    checks++;
    if (ram_r_data !== d) begin
      errors++;
      $display("FAIL b2b_readback: got 0x%08h want 0x%08h", ram_r_data, d);
    end
    run_txn(1'b1, 1'b0, 32'h0000_0300, 4'b0101, $urandom, "b2b_store_partial");
    run_txn(1'b0, 1'b1, 32'h0000_0300, 4'd0, 32'd0, "b2b_load_partial");
  endtask

  task automatic test_top_addr();
    run_txn(1'b0, 1'b1, 32'h0001_FFFC, 4'd0, 32'd0, "top_load");
    run_txn(1'b1, 1'b0, 32'hFFFF_FFFE, 4'b1111, $urandom, "top_store_highbits");
    idle(1);
    run_txn(1'b0, 1'b1, 32'h0003_FFFD, 4'd0, 32'd0, "top_load_highbits");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int op;
    for (int t = 0; t < 24; t++) begin
      a  = {15'($urandom), 17'h400 + 17'($urandom_range(0, 63))};
      op = $urandom_range(0, 2);
      run_txn(op != 0, op != 1, a, 4'($urandom), $urandom, $sformatf("rand%0d", t));
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    preload(17'h100, 8'h11);
    preload(17'h101, 8'h22);
    preload(17'h102, 8'h33);
    preload(17'h103, 8'h44);
    for (int i = 0; i < 4; i++) begin
      preload(17'h200 + 17'(i), 8'($urandom));
      preload(17'h300 + 17'(i), 8'($urandom));
      preload(17'h1FFFC + 17'(i), 8'($urandom));
    end
    for (int i = 0; i < 64; i++) preload(17'h400 + 17'(i), 8'($urandom));
    test_load_basic();
    test_store_lane();
    test_both_enables();
    test_reset_mid_read();
    test_back_to_back();
    test_top_addr();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
